// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the control unit/datapath, the data-memory access sequencer
// and the synchronous data RAM.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [15:0]       AR_output;
  logic [15:0]       WR_data;
  logic              rd_req;
  logic              wr_req;
  logic              busy;
  logic              done;
  logic [15:0]       read_data;
  logic              addr_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  // Sequencer side
  modport slave (
    input  AR_output, WR_data, rd_req, wr_req, mem_rdata,
    output busy, done, read_data, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Control unit / RAM side
  modport master (
    output AR_output, WR_data, rd_req, wr_req, mem_rdata,
    input  busy, done, read_data, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Fixed-latency data-memory access sequencer: one-shot read/write into a synchronous RAM.
// Optional out-of-range address check enabled by defining MEM_ADDR_CHECK_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MEM_DEPTH = 4096
) (
  input  logic              Clock,
  input  logic              Reset,
  mem_access_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state, state_n;
  logic                op_wr, op_wr_n;
  logic [CNT_W-1:0]    cnt, cnt_n;

  logic                busy_n;
  logic                done_n;
  logic                addr_err_n;
  logic                mem_en_n;
  logic                mem_we_n;
  logic [DATA_W-1:0]   read_data_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;

  logic                req_c;
  logic                addr_bad_c;
  logic [ADDR_W-1:0]   req_addr_c;

  assign req_addr_c = bus.AR_output[ADDR_W-1:0];
  assign req_c      = bus.rd_req | bus.wr_req;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_bad_c = (32'(req_addr_c) >= MEM_DEPTH);
`else
  // Depth only matters to the range check; keep it referenced.
  logic unused_depth;
  assign unused_depth = ^32'(MEM_DEPTH);
  assign addr_bad_c   = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    op_wr_n     = op_wr;
    cnt_n       = cnt;
    busy_n      = 1'b1;
    done_n      = 1'b0;
    addr_err_n  = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    read_data_n = bus.read_data;
    mem_addr_n  = bus.mem_addr;
    mem_wdata_n = bus.mem_wdata;

    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (req_c) begin
          // Write has priority; a simultaneous read is dropped.
          op_wr_n     = bus.wr_req;
          mem_addr_n  = req_addr_c;
          mem_wdata_n = bus.WR_data;
          busy_n      = 1'b1;
          if (addr_bad_c) begin
            state_n    = S_DONE;
            done_n     = 1'b1;
            addr_err_n = 1'b1;
            if (!bus.wr_req) begin
              read_data_n = '0;
            end
          end else begin
            state_n  = S_ACCESS;
            mem_en_n = 1'b1;
            mem_we_n = bus.wr_req;
          end
        end
      end

      S_ACCESS: begin
        if (op_wr) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(MEM_LAT - 1);
        end
      end

      S_WAIT: begin
        if (cnt == '0) begin
          state_n     = S_DONE;
          done_n      = 1'b1;
          read_data_n = bus.mem_rdata;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= S_IDLE;
      op_wr         <= 1'b0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.addr_err  <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.read_data <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state         <= state_n;
      op_wr         <= op_wr_n;
      cnt           <= cnt_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
      bus.addr_err  <= addr_err_n;
      bus.mem_en    <= mem_en_n;
      bus.mem_we    <= mem_we_n;
      bus.read_data <= read_data_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-timeline reference model, RAM model with
// fixed read latency, directed literal checks plus randomized requests and resets.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned LAT       = 2;
  localparam int unsigned MEM_DEPTH = 4096;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(
    .ADDR_W   (ADDR_W),
    .MEM_LAT  (LAT),
    .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM with LAT-cycle read pipeline
  logic [15:0] ram     [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] pipe    [LAT];

  always @(posedge clk) begin
    pipe[0] <= ram[bus.mem_addr];
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
  end
  assign bus.mem_rdata = pipe[LAT-1];

  // Reference model: position m_k (1..m_len) inside the current transaction, 0 when idle.
  int          m_k   = 0;
  int          m_len = 0;
  logic        m_wr  = 1'b0;
  logic        m_err = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] exp_rd  = '0;

  always @(posedge clk) begin
    if (m_k == 1 && m_wr && !m_err) ref_mem[m_addr] = m_wdata;
    if (rst) begin
      m_k = 0; m_len = 0; m_wr = 1'b0; m_err = 1'b0;
      m_addr = '0; m_wdata = '0; exp_rd = '0;
    end else if (m_k == 0) begin
      if (bus.rd_req || bus.wr_req) begin
        m_wr    = bus.wr_req;
        m_addr  = bus.AR_output;
        m_wdata = bus.WR_data;
        m_err   = CHECK_EN && (32'(m_addr) >= MEM_DEPTH);
        m_len   = m_err ? 1 : (m_wr ? 2 : 2 + int'(LAT));
        m_k     = 1;
        if (m_err && !m_wr) exp_rd = '0;
      end
    end else if (m_k == m_len) begin
      m_k = 0;
    end else begin
      m_k++;
      if (m_k == m_len && !m_wr) exp_rd = ref_mem[m_addr];
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",      32'(bus.busy),      32'(m_k != 0));
      chk("done",      32'(bus.done),      32'(m_k != 0 && m_k == m_len));
      chk("mem_en",    32'(bus.mem_en),    32'(m_k == 1 && !m_err));
      chk("mem_we",    32'(bus.mem_we),    32'(m_k == 1 && !m_err && m_wr));
      chk("addr_err",  32'(bus.addr_err),  32'(m_k != 0 && m_k == m_len && m_err));
      chk("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      chk("read_data", 32'(bus.read_data), 32'(exp_rd));
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.rd_req = rd; bus.wr_req = wr; bus.AR_output = a; bus.WR_data = d;
    @(posedge clk); #1;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = (bus.busy === 1'b0);
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] a;
    int r;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.AR_output = '0; bus.WR_data = '0;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end

    @(posedge clk); chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_read_data", 32'(bus.read_data), 32'd0);

    // Write 0x0012 <- BEEF
    issue(1'b0, 1'b1, 16'h0012, 16'hBEEF);
    @(negedge clk);
    chk("wr_c1_mem_en", 32'(bus.mem_en), 32'd1);
    chk("wr_c1_mem_we", 32'(bus.mem_we), 32'd1);
    chk("wr_c1_addr", 32'(bus.mem_addr), 32'h0012);
    chk("wr_c1_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    @(negedge clk);
    chk("wr_c2_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("wr_c3_busy", 32'(bus.busy), 32'd0);

    // Read back 0x0012
    issue(1'b1, 1'b0, 16'h0012, 16'h0000);
    @(negedge clk); chk("rd_c1_mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge clk); chk("rd_c2_mem_en", 32'(bus.mem_en), 32'd0);
    @(negedge clk); chk("rd_c3_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("rd_c4_done", 32'(bus.done), 32'd1);
    chk("rd_c4_data", 32'(bus.read_data), 32'hBEEF);
    wait_idle();
    issue(1'b0, 1'b1, 16'h0013, 16'h5555);
    wait_idle();
    chk("rd_hold_after_wr", 32'(bus.read_data), 32'hBEEF);

    // Simultaneous read+write: write wins
    issue(1'b1, 1'b1, 16'h0005, 16'h1234);
    @(negedge clk); chk("both_c1_we", 32'(bus.mem_we), 32'd1);
    @(negedge clk);
    chk("both_c2_done", 32'(bus.done), 32'd1);
    chk("both_rd_unchanged", 32'(bus.read_data), 32'hBEEF);
    wait_idle();
    issue(1'b1, 1'b0, 16'h0005, 16'h0000);
    repeat (4) @(negedge clk);
    chk("both_readback", 32'(bus.read_data), 32'h1234);
    wait_idle();

    // Reset during WAIT, new read accepted on the next edge
    issue(1'b1, 1'b0, 16'h0012, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.rd_req = 1'b1; bus.AR_output = 16'h0012;
    @(negedge clk);
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_read_data", 32'(bus.read_data), 32'd0);
    @(posedge clk); #1; bus.rd_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("rstw_done", 32'(bus.done), 32'(k == 4));
    end
    chk("rstw_data", 32'(bus.read_data), 32'hBEEF);
    wait_idle();

    // Address 0x1000 with depth 4096
    issue(1'b1, 1'b0, 16'h1000, 16'h0000);
`ifdef MEM_ADDR_CHECK_EN
    @(negedge clk);
    chk("oor_mem_en", 32'(bus.mem_en), 32'd0);
    chk("oor_done", 32'(bus.done), 32'd1);
    chk("oor_addr_err", 32'(bus.addr_err), 32'd1);
    chk("oor_read_data", 32'(bus.read_data), 32'd0);
`else
    @(negedge clk);
    chk("hi_mem_en", 32'(bus.mem_en), 32'd1);
    chk("hi_addr", 32'(bus.mem_addr), 32'h1000);
    repeat (3) @(negedge clk);
    chk("hi_done", 32'(bus.done), 32'd1);
    chk("hi_addr_err", 32'(bus.addr_err), 32'd0);
`endif
    wait_idle();

    // Randomized requests, including requests while busy and occasional resets
    for (int it = 0; it < 1500; it++) begin
      @(posedge clk); #1;
      r   = int'($urandom_range(0, 99));
      a   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      rst = (r < 2);
      bus.AR_output = a;
      bus.WR_data   = 16'($urandom);
      if (r >= 2 && r < 35) begin
        case ($urandom_range(0, 2))
          0:       begin bus.rd_req = 1'b1; bus.wr_req = 1'b0; end
          1:       begin bus.rd_req = 1'b0; bus.wr_req = 1'b1; end
          default: begin bus.rd_req = 1'b1; bus.wr_req = 1'b1; end
        endcase
      end else begin
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
